// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte transceiver for the SD-card path: one byte out on MOSI and one in from MISO per start,
// paced by the divider's fast or slow enable strobe. It also owns the card chip-select.
module sd_spi_byte (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       clk_en_fast,
  input  logic       clk_en_slow,
  input  logic       use_fast,
  input  logic       cs_assert,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       sd_sclk,
  output logic       sd_mosi,
  output logic       sd_cs_n,
  input  logic       sd_miso
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  state_t     state_q;
  logic [6:0] tx_shift_q;   // bit 7 goes straight to MOSI at start, so only the remaining 7 bits are kept
  logic [7:0] rx_shift_q;
  logic [7:0] rx_byte_q;
  logic [2:0] bit_cnt_q;
  logic       fast_q;
  logic       done_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       cs_n_q;
  logic       tick;

  assign tick = fast_q ? clk_en_fast : clk_en_slow;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      bit_cnt_q  <= '0;
      fast_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b1;
      cs_n_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sclk_q <= 1'b0;
          cs_n_q <= ~cs_assert;
          if (start) begin
            tx_shift_q <= tx_byte[6:0];
            mosi_q     <= tx_byte[7];
            bit_cnt_q  <= '0;
            fast_q     <= use_fast;
            state_q    <= LOW;
          end else begin
            mosi_q <= 1'b1;
          end
        end
        LOW: begin
          if (tick) begin
            sclk_q     <= 1'b1;
            rx_shift_q <= {rx_shift_q[6:0], sd_miso};
            state_q    <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sclk_q <= 1'b0;
            if (bit_cnt_q == 3'd7) begin
              rx_byte_q <= rx_shift_q;
              done_q    <= 1'b1;
              mosi_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              mosi_q     <= tx_shift_q[6];
              tx_shift_q <= {tx_shift_q[5:0], 1'b0};
              state_q    <= LOW;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rx_byte = rx_byte_q;
  assign sd_sclk = sclk_q;
  assign sd_mosi = mosi_q;
  assign sd_cs_n = cs_n_q;

endmodule

// File: tb/tb_sd_spi_byte.sv
// Directed bench for sd_spi_byte: free-running strobes, a MISO model that shifts on falling sclk,
// and per-cycle tracking of sclk edges, MOSI at rising edges, done pulses and chip-select.
module tb_sd_spi_byte;

  logic       clk_100mhz = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en_fast = 1'b0;
  logic       clk_en_slow = 1'b0;
  logic       use_fast = 1'b0;
  logic       cs_assert = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       sd_sclk;
  logic       sd_mosi;
  logic       sd_cs_n;
  logic       sd_miso = 1'b1;

  sd_spi_byte dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clk_en_fast(clk_en_fast),
    .clk_en_slow(clk_en_slow),
    .use_fast   (use_fast),
    .cs_assert  (cs_assert),
    .start      (start),
    .tx_byte    (tx_byte),
    .busy       (busy),
    .done       (done),
    .rx_byte    (rx_byte),
    .sd_sclk    (sd_sclk),
    .sd_mosi    (sd_mosi),
    .sd_cs_n    (sd_cs_n),
    .sd_miso    (sd_miso)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         s_cyc = 0;
  int         rises = 0;
  int         falls = 0;
  int         dones = 0;
  int         cs_bad = 0;
  int         hi_run = 0;
  int         hi_min = 0;
  int         hi_max = 0;
  int         miso_idx = 0;
  logic [7:0] miso_byte = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  logic       prev_sclk = 1'b0;
  logic       exp_cs_n = 1'b1;
  bit         got;
  int         lat;
  int         busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: inputs and observations happen 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_100mhz);
    #1;
    cyc++;
    if (done === 1'b1) dones++;
    if (sd_sclk === 1'b1 && prev_sclk === 1'b0) begin
      rises++;
      mosi_cap = {mosi_cap[6:0], sd_mosi};
      hi_run = 0;
    end
    if (sd_sclk === 1'b1) hi_run++;
    if (sd_sclk === 1'b0 && prev_sclk === 1'b1) begin
      falls++;
      if (falls == 1 || hi_run < hi_min) hi_min = hi_run;
      if (falls == 1 || hi_run > hi_max) hi_max = hi_run;
      miso_idx++;
      sd_miso = (miso_idx < 8) ? miso_byte[7 - miso_idx] : 1'b1;
    end
    if (busy === 1'b1 && sd_cs_n !== exp_cs_n) cs_bad++;
    prev_sclk = sd_sclk;
    clk_en_fast = ((cyc % 4) == 3);
    clk_en_slow = ((cyc % 512) == 511);
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic fast, input logic [7:0] misob);
    start = 1'b1;
    tx_byte = tx;
    use_fast = fast;
    rises = 0;
    falls = 0;
    dones = 0;
    cs_bad = 0;
    mosi_cap = 8'h00;
    miso_byte = misob;
    miso_idx = 0;
    sd_miso = misob[7];
    step();
    start = 1'b0;
    s_cyc = cyc;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("mosi_bit7_after_start", {31'd0, sd_mosi}, {31'd0, tx[7]});
  endtask

  task automatic wait_done(input int budget, output bit g, output int l);
    g = 1'b0;
    l = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        g = 1'b1;
        l = cyc - s_cyc;
        break;
      end
    end
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      use_fast = 1'($urandom);
      cs_assert = 1'($urandom);
      tx_byte = 8'($urandom);
      sd_miso = 1'($urandom);
      step();
    end
    chk("rst_sclk", {31'd0, sd_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, sd_mosi}, 32'd1);
    chk("rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rx", {24'd0, rx_byte}, 32'h00);
    rst = 1'b0;
    start = 1'b0;
    cs_assert = 1'b1;
    exp_cs_n = 1'b0;
    step();
    step();
    chk("idle_cs_n_asserted", {31'd0, sd_cs_n}, 32'd0);

    // Fast loopback 0xA5 out, 0x3C in
    start_xfer(8'hA5, 1'b1, 8'h3C);
    wait_done(200, got, lat);
    chk("fast_done_seen", {31'd0, got}, 32'd1);
    chk("fast_latency_61_64", {31'd0, (lat >= 61 && lat <= 64)}, 32'd1);
    chk("fast_rx", {24'd0, rx_byte}, 32'h3C);
    chk("fast_mosi_at_rise", {24'd0, mosi_cap}, 32'hA5);
    chk("fast_busy_in_done", {31'd0, busy}, 32'd0);
    chk("fast_mosi_idle_in_done", {31'd0, sd_mosi}, 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("fast_done_once", dones, 32'd1);
    chk("fast_rises", rises, 32'd8);
    chk("fast_falls", falls, 32'd8);
    chk("fast_cs_held", cs_bad, 32'd0);
    chk("fast_rx_held", {24'd0, rx_byte}, 32'h3C);

    // Slow dummy clocks with CS high
    cs_assert = 1'b0;
    exp_cs_n = 1'b1;
    step();
    step();
    start_xfer(8'hFF, 1'b0, 8'h81);
    wait_done(9000, got, lat);
    chk("slow_done_seen", {31'd0, got}, 32'd1);
    chk("slow_latency_7681_8192", {31'd0, (lat >= 7681 && lat <= 8192)}, 32'd1);
    chk("slow_rises", rises, 32'd8);
    chk("slow_high_min", hi_min, 32'd512);
    chk("slow_high_max", hi_max, 32'd512);
    chk("slow_cs_n_high", cs_bad, 32'd0);
    chk("slow_cs_n_now", {31'd0, sd_cs_n}, 32'd1);
    chk("slow_mosi", {24'd0, mosi_cap}, 32'hFF);
    chk("slow_rx", {24'd0, rx_byte}, 32'h81);

    // Busy rejection: 0x12 pulsed mid-byte of 0x40
    cs_assert = 1'b1;
    exp_cs_n = 1'b0;
    step();
    step();
    start_xfer(8'h40, 1'b1, 8'h96);
    for (int i = 0; i < 20; i++) step();
    start = 1'b1;
    tx_byte = 8'h12;
    step();
    start = 1'b0;
    wait_done(200, got, lat);
    chk("rej_done_seen", {31'd0, got}, 32'd1);
    chk("rej_mosi", {24'd0, mosi_cap}, 32'h40);
    chk("rej_rx", {24'd0, rx_byte}, 32'h96);
    busy_seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (busy === 1'b1) busy_seen++;
    end
    chk("rej_no_second_xfer", busy_seen, 32'd0);
    chk("rej_done_once", dones, 32'd1);
    chk("rej_rises", rises, 32'd8);

    // Back-to-back: 0x51 started in the done cycle of 0xFF
    start_xfer(8'hFF, 1'b1, 8'h00);
    wait_done(200, got, lat);
    chk("b2b_first_done", {31'd0, got}, 32'd1);
    chk("b2b_first_rx", {24'd0, rx_byte}, 32'h00);
    chk("b2b_cs_n_in_done", {31'd0, sd_cs_n}, 32'd0);
    start_xfer(8'h51, 1'b1, 8'hC3);
    chk("b2b_cs_n_after", {31'd0, sd_cs_n}, 32'd0);
    wait_done(200, got, lat);
    chk("b2b_second_done", {31'd0, got}, 32'd1);
    chk("b2b_mosi", {24'd0, mosi_cap}, 32'h51);
    chk("b2b_rx", {24'd0, rx_byte}, 32'hC3);
    chk("b2b_cs_held", cs_bad, 32'd0);

    // Reset after the 5th tick of a fast transfer
    start_xfer(8'hA5, 1'b1, 8'h5A);
    for (int i = 0; i < 100 && (rises + falls) < 5; i++) step();
    chk("mid_five_edges", rises + falls, 32'd5);
    chk("mid_sclk_high", {31'd0, sd_sclk}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sclk", {31'd0, sd_sclk}, 32'd0);
    chk("mid_rst_mosi", {31'd0, sd_mosi}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_rx", {24'd0, rx_byte}, 32'h00);
    chk("mid_rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
    for (int i = 0; i < 40; i++) step();
    chk("mid_no_done", dones, 32'd0);
    chk("mid_idle_after", {31'd0, busy}, 32'd0);
    start_xfer(8'h3C, 1'b1, 8'hE7);
    wait_done(200, got, lat);
    chk("post_rst_done", {31'd0, got}, 32'd1);
    chk("post_rst_latency", {31'd0, (lat >= 61 && lat <= 64)}, 32'd1);
    chk("post_rst_mosi", {24'd0, mosi_cap}, 32'h3C);
    chk("post_rst_rx", {24'd0, rx_byte}, 32'hE7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
